// File: rtl/seg7_display_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
//   Shared definitions for the 7-segment display controller:
//   - SEG_BLANK / SEG_DASH codes ({dp, g..a}, active-low)
//   - digit-to-segment table for decimal digits 0..9
//   - controller state enum
//   - seg_lookup(): table access that returns a blank pattern for non-decimal
//     nibbles, so a corrupted nibble never lights an undefined glyph
// -----------------------------------------------------------------------------
package seg7_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DASH  = 8'hBF;

   // Element [d] is the g..a pattern (active-low) for decimal digit d.
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'b0010000,   // 9
      7'b0000000,   // 8
      7'b1111000,   // 7
      7'b0000010,   // 6
      7'b0010010,   // 5
      7'b0011001,   // 4
      7'b0110000,   // 3
      7'b0100100,   // 2
      7'b1111001,   // 1
      7'b1000000    // 0
   };

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_e;

   function automatic logic [6:0] seg_lookup(input logic [3:0] d);
      logic [6:0] r;
      if (d <= 4'd9) begin
         r = SEG_TABLE[d];
      end else begin
         r = 7'h7F;
      end
      return r;
   endfunction

endpackage

// File: rtl/seg7_display_ctrl_encode.sv
// -----------------------------------------------------------------------------
// seg7_encode
//   Combinational encoder for one display digit.
//   Ports:
//     nibble_i  BCD digit to show
//     dp_i      1 = light the decimal point
//     blank_i   1 = digit dark
//     dash_i    1 = show a dash (overflow); dp forced off
//     seg_o     {~dp, g..a}, active-low
// -----------------------------------------------------------------------------
module seg7_encode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble_i,
   input  logic       dp_i,
   input  logic       blank_i,
   input  logic       dash_i,
   output logic [7:0] seg_o
);

   // Priority: dash over blank over normal digit.
   always_comb begin
      seg_o = SEG_BLANK;
      if (dash_i) begin
         seg_o = SEG_DASH;
      end else if (blank_i) begin
         seg_o = SEG_BLANK;
      end else begin
         seg_o = {~dp_i, seg_lookup(nibble_i)};
      end
   end

endmodule

// File: rtl/seg7_display_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_display_ctrl
//   Time-multiplexed multi-digit 7-segment controller. A loaded binary value is
//   converted to BCD by an iterative double-dabble engine (one bit per cycle),
//   then committed atomically to the display registers, which are scanned out
//   one digit per refresh slot.
//   Ports:
//     clk, rst     clock, asynchronous active-high reset
//     value        binary value to display
//     load         start conversion (ignored while busy)
//     dp_pos       digit whose dp is lit (>= DIGITS: none)
//     blank_lz     blank leading zeros
//     busy, done   conversion in progress / one-cycle commit pulse
//     overflow     committed value does not fit in DIGITS decimal digits
//     seg_out      shared {~dp, g..a} bus, active-low, registered
//     digit_en     one-hot-low digit enables, registered
// -----------------------------------------------------------------------------
module seg7_display_ctrl
   import seg7_pkg::*;
#(
   parameter  int DIGITS   = 4,
   parameter  int BIN_W    = 14,
   parameter  int SCAN_DIV = 50000,
   localparam int DP_W     = $clog2(DIGITS + 1)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [BIN_W-1:0]  value,
   input  logic              load,
   input  logic [DP_W-1:0]   dp_pos,
   input  logic              blank_lz,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [7:0]        seg_out,
   output logic [DIGITS-1:0] digit_en
);

   localparam int BCD_W  = 4 * (DIGITS + 1);
   localparam int CNT_W  = $clog2(BIN_W + 1);
   localparam int SCAN_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PRE_W  = $clog2(SCAN_DIV);

   state_e                  state_q, state_d;
   logic [BIN_W-1:0]        bin_q, bin_d;
   logic [BCD_W-1:0]        bcd_q, bcd_d, bcd_adj_s;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    lost_q, lost_d;       // a 1 was shifted out past the top nibble
   logic [DP_W-1:0]         dp_cap_q, dp_cap_d;
   logic                    blz_q, blz_d;
   logic [DIGITS-1:0][3:0]  disp_nib_q, disp_nib_d;
   logic [DIGITS-1:0]       disp_blank_q, disp_blank_d;
   logic [DIGITS-1:0]       disp_dp_q, disp_dp_d;
   logic                    disp_ovf_q, disp_ovf_d;
   logic [DIGITS-1:0]       blank_calc_s, dp_calc_s;
   logic [DP_W-1:0]         dp_eff_s;
   logic                    zero_above_s;
   logic                    busy_q, done_q;
   logic [PRE_W-1:0]        presc_q;
   logic [SCAN_W-1:0]       scan_q;
   logic [7:0]              seg_s, seg_q;
   logic [DIGITS-1:0]       digit_en_q;

   // Double-dabble correction: +3 on every nibble >= 5 before the shift.
   always_comb begin
      bcd_adj_s = bcd_q;
      for (int k = 0; k <= DIGITS; k++) begin
         if (bcd_q[4*k +: 4] >= 4'd5) begin
            bcd_adj_s[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
         end else begin
            bcd_adj_s[4*k +: 4] = bcd_q[4*k +: 4];
         end
      end
   end

   // Leading-zero blanking and dp placement for the value about to be committed.
   always_comb begin
      dp_eff_s     = (dp_cap_q < DP_W'(DIGITS)) ? dp_cap_q : '0;
      zero_above_s = 1'b1;
      blank_calc_s = '0;
      dp_calc_s    = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_above_s    = zero_above_s & (bcd_q[4*i +: 4] == 4'd0);
         blank_calc_s[i] = blz_q & zero_above_s & (DP_W'(i) > dp_eff_s);
         dp_calc_s[i]    = (dp_cap_q == DP_W'(i));
      end
   end

   // Conversion FSM next-state and datapath.
   always_comb begin
      state_d      = state_q;
      bin_d        = bin_q;
      bcd_d        = bcd_q;
      cnt_d        = cnt_q;
      lost_d       = lost_q;
      dp_cap_d     = dp_cap_q;
      blz_d        = blz_q;
      disp_nib_d   = disp_nib_q;
      disp_blank_d = disp_blank_q;
      disp_dp_d    = disp_dp_q;
      disp_ovf_d   = disp_ovf_q;
      case (state_q)
         IDLE: begin
            if (load) begin
               bin_d    = value;
               bcd_d    = '0;
               cnt_d    = '0;
               lost_d   = 1'b0;
               dp_cap_d = dp_pos;
               blz_d    = blank_lz;
               state_d  = SHIFT;
            end else begin
               state_d  = IDLE;
            end
         end
         SHIFT: begin
            bcd_d  = {bcd_adj_s[BCD_W-2:0], bin_q[BIN_W-1]};
            lost_d = lost_q | bcd_adj_s[BCD_W-1];
            bin_d  = bin_q << 1;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BIN_W - 1)) begin
               state_d = COMMIT;
            end else begin
               state_d = SHIFT;
            end
         end
         COMMIT: begin
            disp_nib_d   = bcd_q[4*DIGITS-1:0];
            disp_blank_d = blank_calc_s;
            disp_dp_d    = dp_calc_s;
            disp_ovf_d   = lost_q | (bcd_q[BCD_W-1 -: 4] != 4'd0);
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM, conversion and display registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         bin_q        <= '0;
         bcd_q        <= '0;
         cnt_q        <= '0;
         lost_q       <= 1'b0;
         dp_cap_q     <= '0;
         blz_q        <= 1'b0;
         disp_nib_q   <= '0;
         disp_blank_q <= '1;
         disp_dp_q    <= '0;
         disp_ovf_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         bin_q        <= bin_d;
         bcd_q        <= bcd_d;
         cnt_q        <= cnt_d;
         lost_q       <= lost_d;
         dp_cap_q     <= dp_cap_d;
         blz_q        <= blz_d;
         disp_nib_q   <= disp_nib_d;
         disp_blank_q <= disp_blank_d;
         disp_dp_q    <= disp_dp_d;
         disp_ovf_q   <= disp_ovf_d;
         busy_q       <= (state_d != IDLE);
         done_q       <= (state_d == COMMIT);
      end
   end

   seg7_encode u_encode (
      .nibble_i (disp_nib_q[scan_q]),
      .dp_i     (disp_dp_q[scan_q]),
      .blank_i  (disp_blank_q[scan_q]),
      .dash_i   (disp_ovf_q),
      .seg_o    (seg_s)
   );

   // Refresh prescaler, scan index and registered display outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q    <= '0;
         scan_q     <= '0;
         seg_q      <= SEG_BLANK;
         digit_en_q <= '1;
      end else begin
         if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
            presc_q <= '0;
            scan_q  <= (scan_q == SCAN_W'(DIGITS - 1)) ? '0 : scan_q + SCAN_W'(1);
         end else begin
            presc_q <= presc_q + PRE_W'(1);
         end
         seg_q      <= seg_s;
         digit_en_q <= ~(DIGITS'(1) << scan_q);
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign overflow = disp_ovf_q;
   assign seg_out  = seg_q;
   assign digit_en = digit_en_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_display_ctrl
//   Directed bench for seg7_display_ctrl (DIGITS=4, BIN_W=14, SCAN_DIV=4).
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_seg7_display_ctrl;

   localparam int DIGITS   = 4;
   localparam int BIN_W    = 14;
   localparam int SCAN_DIV = 4;
   localparam int DP_W     = $clog2(DIGITS + 1);

   logic              clk;
   logic              rst;
   logic [BIN_W-1:0]  value;
   logic              load;
   logic [DP_W-1:0]   dp_pos;
   logic              blank_lz;
   logic              busy;
   logic              done;
   logic              overflow;
   logic [7:0]        seg_out;
   logic [DIGITS-1:0] digit_en;

   int n_checks;
   int n_errors;
   int busy_n;
   int done_n;

   seg7_display_ctrl #(
      .DIGITS   (DIGITS),
      .BIN_W    (BIN_W),
      .SCAN_DIV (SCAN_DIV)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .value    (value),
      .load     (load),
      .dp_pos   (dp_pos),
      .blank_lz (blank_lz),
      .busy     (busy),
      .done     (done),
      .overflow (overflow),
      .seg_out  (seg_out),
      .digit_en (digit_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Load a value and follow the conversion until busy drops; optionally
   // pulse a second load 'second_at' cycles into the conversion.
   task automatic run_load(input int val, input int dp, input logic blz,
                           input int second_at, input int second_val);
      @(negedge clk);
      value    = BIN_W'(val);
      dp_pos   = DP_W'(dp);
      blank_lz = blz;
      load     = 1'b1;
      @(negedge clk);
      load   = 1'b0;
      busy_n = 0;
      done_n = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy) busy_n++;
         if (done) done_n++;
         if (!busy) break;
         if (i == second_at) begin
            value = BIN_W'(second_val);
            load  = 1'b1;
         end else begin
            load  = 1'b0;
         end
         @(negedge clk);
      end
      load = 1'b0;
   endtask

   // Wait (bounded) until digit idx is enabled, then check its segments.
   task automatic check_digit(input string tag, input int idx, input logic [7:0] exp);
      logic [DIGITS-1:0] want;
      bit found;
      want  = ~(DIGITS'(1) << idx);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (digit_en == want) begin
            found = 1'b1;
            break;
         end
      end
      if (found) begin
         check_eq(tag, {24'd0, seg_out}, {24'd0, exp});
      end else begin
         check_eq({tag, "_scan_timeout"}, {28'd0, digit_en}, {28'd0, want});
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b1;
      load     = 1'b0;
      value    = '0;
      dp_pos   = '0;
      blank_lz = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_busy",     {31'd0, busy},     32'd0);
      check_eq("rst_done",     {31'd0, done},     32'd0);
      check_eq("rst_overflow", {31'd0, overflow}, 32'd0);
      check_eq("rst_seg",      {24'd0, seg_out},  32'hFF);
      check_eq("rst_digit_en", {28'd0, digit_en}, 32'hF);
      rst = 1'b0;
      check_digit("idle_blank_d2", 2, 8'hFF);
      check_eq("onehot_en", $countones(~digit_en), 32'd1);

      // 1234, no dp, no blanking
      run_load(1234, 4, 1'b0, -1, 0);
      check_eq("t2_busy_cycles", busy_n, 32'd15);
      check_eq("t2_done_pulses", done_n, 32'd1);
      check_eq("t2_overflow", {31'd0, overflow}, 32'd0);
      check_digit("t2_d0", 0, 8'h99);
      check_digit("t2_d1", 1, 8'hB0);
      check_digit("t2_d2", 2, 8'hA4);
      check_digit("t2_d3", 3, 8'hF9);

      // 7 with leading-zero blanking
      run_load(7, 4, 1'b1, -1, 0);
      check_eq("t3_done_pulses", done_n, 32'd1);
      check_digit("t3_d3", 3, 8'hFF);
      check_digit("t3_d2", 2, 8'hFF);
      check_digit("t3_d1", 1, 8'hFF);
      check_digit("t3_d0", 0, 8'hF8);

      // 250 with dp on digit 2: zero blanking stops at the dp digit
      run_load(250, 2, 1'b1, -1, 0);
      check_digit("t4_d3", 3, 8'hFF);
      check_digit("t4_d2", 2, 8'h24);
      check_digit("t4_d1", 1, 8'h92);
      check_digit("t4_d0", 0, 8'hC0);

      // overflow then the largest value that fits
      run_load(10000, 1, 1'b0, -1, 0);
      check_eq("t5_ovf_set", {31'd0, overflow}, 32'd1);
      check_digit("t5_ovf_d0", 0, 8'hBF);
      check_digit("t5_ovf_d1", 1, 8'hBF);
      check_digit("t5_ovf_d3", 3, 8'hBF);
      run_load(9999, 4, 1'b0, -1, 0);
      check_eq("t5_ovf_clr", {31'd0, overflow}, 32'd0);
      check_digit("t5_d0", 0, 8'h90);
      check_digit("t5_d1", 1, 8'h90);
      check_digit("t5_d2", 2, 8'h90);
      check_digit("t5_d3", 3, 8'h90);

      // second load while busy is dropped
      run_load(42, 4, 1'b0, 3, 99);
      check_eq("t6_busy_cycles", busy_n, 32'd15);
      check_eq("t6_done_pulses", done_n, 32'd1);
      repeat (5) @(negedge clk);
      check_eq("t6_stays_idle", {31'd0, busy}, 32'd0);
      check_digit("t6_d0", 0, 8'hA4);
      check_digit("t6_d1", 1, 8'h99);
      check_digit("t6_d2", 2, 8'hC0);
      check_digit("t6_d3", 3, 8'hC0);

      // asynchronous reset in the middle of a conversion
      @(negedge clk);
      value = BIN_W'(1234);
      load  = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (4) @(negedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check_eq("t1_busy",     {31'd0, busy},     32'd0);
      check_eq("t1_seg",      {24'd0, seg_out},  32'hFF);
      check_eq("t1_digit_en", {28'd0, digit_en}, 32'hF);
      repeat (2) @(negedge clk);
      rst    = 1'b0;
      done_n = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (done) done_n++;
      end
      check_eq("t1_no_done", done_n, 32'd0);
      check_eq("t1_idle", {31'd0, busy}, 32'd0);
      check_digit("t1_blank_d1", 1, 8'hFF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
